// File: rtl/halut_cfg_loader.sv
// halut_cfg_loader
// ----------------
// Configuration sequencer for the halutmatmul accelerator. Takes a single
// valid/ready stream of configuration words and writes them, in a fixed
// order, first into the encoder threshold memories and then into the decoder
// LUT memories. done_o tells the host that compute may be enabled.
//
// Optional feature: define HALUT_CFG_CHECKSUM_EN to append a checksum beat.
// The checksum is the running XOR of all table words. It is checked in a
// CHECK state, produces no write, and carries cfg_last_i instead of the final
// table word.
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   start_i                    begin a load sequence (IDLE only)
//   cfg_valid_i / cfg_ready_o  config stream handshake
//   cfg_data_i, cfg_last_i     config word and end-of-sequence marker
//   waddr_enc_o, wdata_enc_o   encoder threshold write address/data (broadcast)
//   we_enc_o                   one-hot write enable per encoder unit
//   m_addr_dec_o               decoder sub-unit select (broadcast)
//   waddr_dec_o, wdata_dec_o   decoder LUT write address/data (broadcast)
//   we_dec_o                   one-hot write enable per decoder group
//   busy_o, done_o, error_o    sequence status (done/error sticky until start)
//
// States
//   state    | meaning
//   IDLE     | waiting for start_i, stream not accepted
//   LOAD_ENC | accepting encoder threshold words
//   LOAD_DEC | accepting decoder LUT words
//   CHECK    | accepting the checksum word (checksum build only)
//   FINISH   | raise done_o, return to IDLE
//   FAIL     | raise error_o, return to IDLE
module halut_cfg_loader #(
  parameter int K             = 16,
  parameter int C             = 32,
  parameter int M             = 32,
  parameter int DataTypeWidth = 16,
  parameter int DecoderUnits  = 16,
  parameter int EncUnits      = 4,
  // derived, do not override
  localparam int DecUnitsX = M / DecoderUnits,
  localparam int EncDepth  = (C / EncUnits) * K,
  localparam int DecDepth  = C * K,
  localparam int EncWords  = C * K,
  localparam int DecWords  = M * C * K,
  localparam int EncAddrW  = (EncDepth > 1) ? $clog2(EncDepth) : 1,
  localparam int DecAddrW  = (DecDepth > 1) ? $clog2(DecDepth) : 1,
  localparam int MSelW     = (DecoderUnits > 1) ? $clog2(DecoderUnits) : 1,
  localparam int EncSelW   = (EncUnits > 1) ? $clog2(EncUnits) : 1,
  localparam int DecSelW   = (DecUnitsX > 1) ? $clog2(DecUnitsX) : 1,
  localparam int CntW      = $clog2(EncWords + DecWords + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [DataTypeWidth-1:0] cfg_data_i,
  input  logic                     cfg_last_i,
  output logic [EncAddrW-1:0]      waddr_enc_o,
  output logic [DataTypeWidth-1:0] wdata_enc_o,
  output logic [EncUnits-1:0]      we_enc_o,
  output logic [MSelW-1:0]         m_addr_dec_o,
  output logic [DecAddrW-1:0]      waddr_dec_o,
  output logic [DataTypeWidth-1:0] wdata_dec_o,
  output logic [DecUnitsX-1:0]     we_dec_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o
);

`ifdef HALUT_CFG_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_ENC = 3'd1,
    ST_LOAD_DEC = 3'd2,
    ST_CHECK    = 3'd3,
    ST_FINISH   = 3'd4,
    ST_FAIL     = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_ENC = 3'd1,
    ST_LOAD_DEC = 3'd2,
    ST_FINISH   = 3'd4,
    ST_FAIL     = 3'd5
  } state_t;
`endif

  state_t r_state;

  logic                     r_ready;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_error;
  logic [EncAddrW-1:0]      r_waddr_enc;
  logic [DataTypeWidth-1:0] r_wdata_enc;
  logic [EncUnits-1:0]      r_we_enc;
  logic [MSelW-1:0]         r_m_addr_dec;
  logic [DecAddrW-1:0]      r_waddr_dec;
  logic [DataTypeWidth-1:0] r_wdata_dec;
  logic [DecUnitsX-1:0]     r_we_dec;

  // Running word index across both tables, plus the per-table address fields.
  logic [CntW-1:0]     r_cnt;
  logic [EncAddrW-1:0] r_enc_addr;
  logic [EncSelW-1:0]  r_enc_unit;
  logic [DecAddrW-1:0] r_dec_addr;
  logic [MSelW-1:0]    r_dec_m;
  logic [DecSelW-1:0]  r_dec_x;

  logic                w_hs;
  logic                w_enc_final;
  logic                w_dec_final;
  logic [EncUnits-1:0] w_enc_onehot;
  logic [DecUnitsX-1:0] w_dec_onehot;

  assign w_hs         = cfg_valid_i & r_ready;
  assign w_enc_final  = (r_cnt == CntW'(EncWords - 1));
  assign w_dec_final  = (r_cnt == CntW'(EncWords + DecWords - 1));
  assign w_enc_onehot = EncUnits'(1) << r_enc_unit;
  assign w_dec_onehot = DecUnitsX'(1) << r_dec_x;

`ifdef HALUT_CFG_CHECKSUM_EN
  logic [DataTypeWidth-1:0] r_csum;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_csum <= '0;
    end else if (r_state == ST_IDLE && start_i) begin
      r_csum <= '0;
    end else if (w_hs && (r_state == ST_LOAD_ENC || r_state == ST_LOAD_DEC)) begin
      r_csum <= r_csum ^ cfg_data_i;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_waddr_enc  <= '0;
      r_wdata_enc  <= '0;
      r_we_enc     <= '0;
      r_m_addr_dec <= '0;
      r_waddr_dec  <= '0;
      r_wdata_dec  <= '0;
      r_we_dec     <= '0;
      r_cnt        <= '0;
      r_enc_addr   <= '0;
      r_enc_unit   <= '0;
      r_dec_addr   <= '0;
      r_dec_m      <= '0;
      r_dec_x      <= '0;
    end else begin
      // Strobes are single-cycle: only a handshake in the current cycle
      // re-asserts one of them.
      r_we_enc <= '0;
      r_we_dec <= '0;

      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b1;
            r_ready    <= 1'b1;
            r_cnt      <= '0;
            r_enc_addr <= '0;
            r_enc_unit <= '0;
            r_dec_addr <= '0;
            r_dec_m    <= '0;
            r_dec_x    <= '0;
            r_state    <= ST_LOAD_ENC;
          end
        end

        ST_LOAD_ENC: begin
          if (w_hs) begin
            r_we_enc    <= w_enc_onehot;
            r_waddr_enc <= r_enc_addr;
            r_wdata_enc <= cfg_data_i;
            r_cnt       <= r_cnt + 1'b1;
            if (r_enc_addr == EncAddrW'(EncDepth - 1)) begin
              r_enc_addr <= '0;
              r_enc_unit <= r_enc_unit + 1'b1;
            end else begin
              r_enc_addr <= r_enc_addr + 1'b1;
            end
            // The final word can never sit in the encoder table, so any
            // last marker here is premature.
            if (cfg_last_i) begin
              r_ready <= 1'b0;
              r_state <= ST_FAIL;
            end else if (w_enc_final) begin
              r_state <= ST_LOAD_DEC;
            end
          end
        end

        ST_LOAD_DEC: begin
          if (w_hs) begin
            r_we_dec     <= w_dec_onehot;
            r_m_addr_dec <= r_dec_m;
            r_waddr_dec  <= r_dec_addr;
            r_wdata_dec  <= cfg_data_i;
            r_cnt        <= r_cnt + 1'b1;
            if (r_dec_addr == DecAddrW'(DecDepth - 1)) begin
              r_dec_addr <= '0;
              if (r_dec_m == MSelW'(DecoderUnits - 1)) begin
                r_dec_m <= '0;
                r_dec_x <= r_dec_x + 1'b1;
              end else begin
                r_dec_m <= r_dec_m + 1'b1;
              end
            end else begin
              r_dec_addr <= r_dec_addr + 1'b1;
            end
`ifdef HALUT_CFG_CHECKSUM_EN
            // The checksum beat carries last, so last on any table word fails.
            if (cfg_last_i) begin
              r_ready <= 1'b0;
              r_state <= ST_FAIL;
            end else if (w_dec_final) begin
              r_state <= ST_CHECK;
            end
`else
            if (w_dec_final) begin
              r_ready <= 1'b0;
              r_state <= cfg_last_i ? ST_FINISH : ST_FAIL;
            end else if (cfg_last_i) begin
              r_ready <= 1'b0;
              r_state <= ST_FAIL;
            end
`endif
          end
        end

`ifdef HALUT_CFG_CHECKSUM_EN
        ST_CHECK: begin
          if (w_hs) begin
            r_ready <= 1'b0;
            if (cfg_last_i && (cfg_data_i == r_csum)) begin
              r_state <= ST_FINISH;
            end else begin
              r_state <= ST_FAIL;
            end
          end
        end
`endif

        ST_FINISH: begin
          r_ready <= 1'b0;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        ST_FAIL: begin
          r_ready <= 1'b0;
          r_error <= 1'b1;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_ready_o  = r_ready;
  assign waddr_enc_o  = r_waddr_enc;
  assign wdata_enc_o  = r_wdata_enc;
  assign we_enc_o     = r_we_enc;
  assign m_addr_dec_o = r_m_addr_dec;
  assign waddr_dec_o  = r_waddr_dec;
  assign wdata_dec_o  = r_wdata_dec;
  assign we_dec_o     = r_we_dec;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign error_o      = r_error;

endmodule

// File: tb/tb_halut_cfg_loader.sv
// Testbench for halut_cfg_loader with a small configuration
// (K=4, C=4, M=4, DecoderUnits=2, EncUnits=4). A reference model maps each
// accepted word index to its expected write target with plain arithmetic.
module tb_halut_cfg_loader;

  localparam int KP    = 4;
  localparam int CP    = 4;
  localparam int MP    = 4;
  localparam int DW    = 16;
  localparam int DU    = 2;
  localparam int EU    = 4;
  localparam int EDEP  = (CP / EU) * KP;   // 4
  localparam int DDEP  = CP * KP;          // 16
  localparam int NENC  = CP * KP;          // 16
  localparam int NDEC  = MP * CP * KP;     // 64
  localparam int NW    = NENC + NDEC;      // 80

  logic          clk_sys;
  logic          rst_i;
  logic          start_i;
  logic          cfg_valid_i;
  logic          cfg_ready_o;
  logic [DW-1:0] cfg_data_i;
  logic          cfg_last_i;
  logic [1:0]    waddr_enc_o;
  logic [DW-1:0] wdata_enc_o;
  logic [3:0]    we_enc_o;
  logic [0:0]    m_addr_dec_o;
  logic [3:0]    waddr_dec_o;
  logic [DW-1:0] wdata_dec_o;
  logic [1:0]    we_dec_o;
  logic          busy_o;
  logic          done_o;
  logic          error_o;

  halut_cfg_loader #(
    .K(KP), .C(CP), .M(MP), .DataTypeWidth(DW), .DecoderUnits(DU), .EncUnits(EU)
  ) dut (
    .clk_i       (clk_sys),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_data_i  (cfg_data_i),
    .cfg_last_i  (cfg_last_i),
    .waddr_enc_o (waddr_enc_o),
    .wdata_enc_o (wdata_enc_o),
    .we_enc_o    (we_enc_o),
    .m_addr_dec_o(m_addr_dec_o),
    .waddr_dec_o (waddr_dec_o),
    .wdata_dec_o (wdata_dec_o),
    .we_dec_o    (we_dec_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int n_tot = 0;
  int n_bad = 0;
  int n_wr  = 0;
  int model_idx = 0;
  int cyc = 0;

  // Per-index capture of observed strobes, for the spot checks.
  logic [3:0] cap_we_enc  [0:NW];
  logic [1:0] cap_waddr_enc [0:NW];
  logic [1:0] cap_we_dec  [0:NW];
  logic [0:0] cap_m       [0:NW];
  logic [3:0] cap_waddr_dec [0:NW];

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Monitor: a handshake seen before edge N must produce exactly one strobe
  // after edge N; cycles without a handshake must produce none.
  bit            pend_vld = 1'b0;
  int            pend_idx = 0;
  logic [DW-1:0] pend_data = '0;

  always @(negedge clk_sys) begin : mon
    int e, a, j, x, m;
    if (pend_vld && pend_idx < NW) begin
      if (pend_idx < NENC) begin
        e = pend_idx / EDEP;
        a = pend_idx % EDEP;
        chk_val("we_enc", 32'(we_enc_o), 32'(1 << e));
        chk_val("we_dec_quiet", 32'(we_dec_o), 0);
        chk_val("waddr_enc", 32'(waddr_enc_o), 32'(a));
        chk_val("wdata_enc", 32'(wdata_enc_o), 32'(pend_data));
      end else begin
        j = pend_idx - NENC;
        x = j / (DU * DDEP);
        m = (j / DDEP) % DU;
        a = j % DDEP;
        chk_val("we_dec", 32'(we_dec_o), 32'(1 << x));
        chk_val("we_enc_quiet", 32'(we_enc_o), 0);
        chk_val("m_addr_dec", 32'(m_addr_dec_o), 32'(m));
        chk_val("waddr_dec", 32'(waddr_dec_o), 32'(a));
        chk_val("wdata_dec", 32'(wdata_dec_o), 32'(pend_data));
      end
      cap_we_enc[pend_idx]    = we_enc_o;
      cap_waddr_enc[pend_idx] = waddr_enc_o;
      cap_we_dec[pend_idx]    = we_dec_o;
      cap_m[pend_idx]         = m_addr_dec_o;
      cap_waddr_dec[pend_idx] = waddr_dec_o;
      n_wr++;
    end else begin
      chk_val("no_write", 32'({we_enc_o, we_dec_o}), 0);
    end
    pend_vld = cfg_valid_i && cfg_ready_o && !rst_i;
    if (pend_vld) begin
      pend_idx  = model_idx;
      pend_data = cfg_data_i;
      model_idx++;
    end
  end

  task automatic do_start();
    model_idx = 0;
    n_wr = 0;
    for (int i = 0; i <= NW; i++) begin
      cap_we_enc[i] = '0; cap_waddr_enc[i] = '0; cap_we_dec[i] = '0;
      cap_m[i] = '0; cap_waddr_dec[i] = '0;
    end
    start_i = 1'b1;
    @(posedge clk_sys); #1;
    start_i = 1'b0;
    chk_val("start_done_clr", 32'(done_o), 0);
    chk_val("start_err_clr", 32'(error_o), 0);
    chk_val("start_busy", 32'(busy_o), 1);
    chk_val("start_ready", 32'(cfg_ready_o), 1);
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic l, input int gap_pct);
    bit got;
    got = 1'b0;
    while (int'($urandom_range(99)) < gap_pct) begin
      cfg_valid_i = 1'b0;
      @(posedge clk_sys); #1;
    end
    cfg_valid_i = 1'b1;
    cfg_data_i  = d;
    cfg_last_i  = l;
    for (int t = 0; t < 64 && !got; t++) begin
      @(negedge clk_sys);
      got = cfg_ready_o;
      @(posedge clk_sys); #1;
    end
    chk_val("hs_timeout", 32'(got), 1);
    cfg_valid_i = 1'b0;
    cfg_last_i  = 1'b0;
  endtask

  // Full load of all tables. glitch_at pulses start_i alongside that word;
  // csum_err is XORed into the checksum beat (checksum build only).
  task automatic run_full(input int gap, input bit rnd, input int glitch_at,
                          input logic [DW-1:0] csum_err, input bit expect_ok);
    logic [DW-1:0] d, x;
    logic          l;
    int            t0;
    do_start();
    x  = '0;
    t0 = cyc;
    for (int i = 0; i < NW; i++) begin
      d = rnd ? DW'($urandom) : DW'(i);
      x = x ^ d;
`ifdef HALUT_CFG_CHECKSUM_EN
      l = 1'b0;
`else
      l = (i == NW - 1);
`endif
      if (i == glitch_at) start_i = 1'b1;
      send_word(d, l, gap);
      start_i = 1'b0;
    end
    if (gap == 0) chk_val("zero_bubble_cycles", 32'(cyc - t0), 32'(NW));
`ifdef HALUT_CFG_CHECKSUM_EN
    send_word(x ^ csum_err, 1'b1, gap);
`endif
    @(negedge clk_sys);
    chk_val("done_not_early", 32'(done_o), 0);
    @(posedge clk_sys); #1;
    chk_val("done", 32'(done_o), 32'(expect_ok));
    chk_val("error", 32'(error_o), 32'(!expect_ok));
    chk_val("busy_end", 32'(busy_o), 0);
    chk_val("ready_end", 32'(cfg_ready_o), 0);
    repeat (2) @(posedge clk_sys);
    #1;
    chk_val("write_count", 32'(n_wr), 32'(NW));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0; cfg_valid_i = 1'b0; cfg_data_i = '0; cfg_last_i = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    rst_i = 1'b0;
    chk_val("rst_ready", 32'(cfg_ready_o), 0);
    chk_val("rst_busy", 32'(busy_o), 0);
    chk_val("rst_done", 32'(done_o), 0);
    chk_val("rst_error", 32'(error_o), 0);
    chk_val("rst_we", 32'({we_enc_o, we_dec_o}), 0);
    chk_val("rst_addr", 32'({waddr_enc_o, m_addr_dec_o, waddr_dec_o}), 0);

    // Valid in IDLE is not accepted.
    cfg_valid_i = 1'b1; cfg_data_i = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      chk_val("idle_ready", 32'(cfg_ready_o), 0);
    end
    @(posedge clk_sys); #1;
    cfg_valid_i = 1'b0;

    // 1: back-to-back, data = index
    run_full(0, 1'b0, -1, '0, 1'b1);
    chk_val("w5_we_enc", 32'(cap_we_enc[5]), 32'h2);
    chk_val("w5_waddr_enc", 32'(cap_waddr_enc[5]), 1);
    chk_val("w53_we_dec", 32'(cap_we_dec[53]), 32'h2);
    chk_val("w53_m_addr", 32'(cap_m[53]), 0);
    chk_val("w53_waddr_dec", 32'(cap_waddr_dec[53]), 5);

    // 2: random gaps, random data
    run_full(50, 1'b1, -1, '0, 1'b1);

    // 3: premature last on word 10
    do_start();
    for (int i = 0; i <= 10; i++) send_word(DW'($urandom), (i == 10), 30);
    @(posedge clk_sys); #1;
    chk_val("early_last_error", 32'(error_o), 1);
    chk_val("early_last_done", 32'(done_o), 0);
    chk_val("early_last_ready", 32'(cfg_ready_o), 0);
    chk_val("early_last_busy", 32'(busy_o), 0);
    repeat (4) @(posedge clk_sys);
    #1;
    chk_val("early_last_writes", 32'(n_wr), 11);
    chk_val("w10_we_enc", 32'(cap_we_enc[10]), 32'h4);
    chk_val("w10_waddr_enc", 32'(cap_waddr_enc[10]), 2);

    // 4: reset at word 30, then a fresh load
    do_start();
    for (int i = 0; i < 30; i++) send_word(DW'($urandom), 1'b0, 0);
    rst_i = 1'b1; cfg_valid_i = 1'b1; cfg_data_i = 16'hBEEF;
    @(posedge clk_sys); #1;
    rst_i = 1'b0; cfg_valid_i = 1'b0;
    chk_val("midrst_ready", 32'(cfg_ready_o), 0);
    chk_val("midrst_status", 32'({busy_o, done_o, error_o}), 0);
    chk_val("midrst_we", 32'({we_enc_o, we_dec_o}), 0);
    chk_val("midrst_addr", 32'({waddr_enc_o, m_addr_dec_o, waddr_dec_o}), 0);
    chk_val("midrst_data", 32'({wdata_enc_o, wdata_dec_o}), 0);
    chk_val("midrst_writes", 32'(n_wr), 30);
    run_full(0, 1'b1, -1, '0, 1'b1);
    chk_val("restart_we_enc", 32'(cap_we_enc[0]), 32'h1);
    chk_val("restart_waddr_enc", 32'(cap_waddr_enc[0]), 0);

    // 5: start pulsed in LOAD_DEC is ignored
    run_full(0, 1'b1, 40, '0, 1'b1);

`ifdef HALUT_CFG_CHECKSUM_EN
    // 6: checksum match and mismatch (data = index, XOR of 0..79 is 0)
    run_full(0, 1'b0, -1, '0, 1'b1);
    run_full(0, 1'b0, -1, 16'h0001, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
